// File: rtl/rob_pkg.sv
// Shared definitions for the reorder-buffer retire slice: entry layout,
// geometry and the retire state enum.
package rob_pkg;

  localparam int DEPTH   = 64;
  localparam int IDX_W   = 6;
  localparam int DATA_W  = 16;
  localparam int ENTRY_W = 38;

  // Entry layout: {ready, wreg, dest[2:0], value[15:0], halt, pc[15:0]}
  localparam int PC_LSB   = 0;
  localparam int PC_MSB   = 15;
  localparam int HALT_B   = 16;
  localparam int VAL_LSB  = 17;
  localparam int VAL_MSB  = 32;
  localparam int DEST_LSB = 33;
  localparam int DEST_MSB = 35;
  localparam int WREG_B   = 36;
  localparam int READY_B  = 37;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } robState_t;

endpackage

// File: rtl/rob_commit_sel.sv
// Combinational commit selection for the two head entries: decides which
// entries retire this cycle, which of them write a register, and whether a
// halt instruction retires. Holds no state; the parent owns every flop.
module rob_commit_sel
  import rob_pkg::*;
(
  input  logic               isRun,
  input  logic [IDX_W:0]     count,
  input  logic [ENTRY_W-1:0] entry0,
  input  logic [ENTRY_W-1:0] entry1,
  output logic               c0,
  output logic               c1,
  output logic [1:0]         nCommit,
  output logic               selWen0,
  output logic               selWen1,
  output logic               haltCommit
);

  // Value and pc fields are consumed by the parent, not here.
  logic unusedFields;
  assign unusedFields = ^{entry0[VAL_MSB:VAL_LSB], entry0[PC_MSB:PC_LSB],
                          entry1[VAL_MSB:VAL_LSB], entry1[PC_MSB:PC_LSB]};

  // In-order retire of up to two ready entries; a halt stops the pair.
  always_comb begin
    // NOTE: every output gets a value first so no path leaves one unassigned (no latch).
    c0         = 1'b0;
    c1         = 1'b0;
    selWen0    = 1'b0;
    selWen1    = 1'b0;
    haltCommit = 1'b0;

    c0 = isRun && (count != '0) && entry0[READY_B];
    c1 = c0 && (count > (IDX_W+1)'(1)) && entry1[READY_B] && !entry0[HALT_B];

    selWen0 = c0 && entry0[WREG_B] && !entry0[HALT_B];
    selWen1 = c1 && entry1[WREG_B] && !entry1[HALT_B];

    // Younger write wins so the register file never sees a same-address pair.
    if (selWen0 && selWen1 &&
        (entry0[DEST_MSB:DEST_LSB] == entry1[DEST_MSB:DEST_LSB]))
      selWen0 = 1'b0;

    haltCommit = (c0 && entry0[HALT_B]) || (c1 && entry1[HALT_B]);
    nCommit    = {1'b0, c0} + {1'b0, c1};
  end

endmodule

// File: rtl/rob_retire.sv
// Retire end of the 64-entry reorder buffer. Commits up to two ready
// entries per cycle from the head, drives the register write ports one
// cycle later, and tracks occupancy, stall, halt and over-allocation.
// Optional: define ROB_RETIRE_CNT_EN to build the 32-bit retired counter.
module rob_retire
  import rob_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         alloc_cnt,
  input  logic               flush,
  input  logic [IDX_W-1:0]   flush_ptr,
  output logic [IDX_W-1:0]   rd_addr0,
  output logic [IDX_W-1:0]   rd_addr1,
  input  logic [ENTRY_W-1:0] rd_entry0,
  input  logic [ENTRY_W-1:0] rd_entry1,
  output logic               wen0,
  output logic               wen1,
  output logic [2:0]         waddr0,
  output logic [2:0]         waddr1,
  output logic [DATA_W-1:0]  wdata0,
  output logic [DATA_W-1:0]  wdata1,
  output logic [IDX_W-1:0]   wtag0,
  output logic [IDX_W-1:0]   wtag1,
  output logic [IDX_W-1:0]   head,
  output logic [IDX_W:0]     count,
  output logic               stall,
  output logic               halted,
  output logic               alloc_err,
  output logic [31:0]        retired
);

  robState_t         state, stateNext;
  logic              c0, c1, selWen0, selWen1, haltCommit;
  logic [1:0]        nCommit;
  logic [IDX_W+1:0]  freeSlots;
  logic              allocOk;
  logic [IDX_W:0]    countNext;

  assign rd_addr0 = head;
  assign rd_addr1 = head + IDX_W'(1);
  assign stall    = count > (IDX_W+1)'(DEPTH - 4);
  assign halted   = (state == HALTED);

  rob_commit_sel u_sel (
    .isRun      (state == RUN),
    .count      (count),
    .entry0     (rd_entry0),
    .entry1     (rd_entry1),
    .c0         (c0),
    .c1         (c1),
    .nCommit    (nCommit),
    .selWen0    (selWen0),
    .selWen1    (selWen1),
    .haltCommit (haltCommit)
  );

  // Free slots include those vacated by this cycle's commits.
  always_comb begin
    freeSlots = (IDX_W+2)'(DEPTH) - {1'b0, count} + (IDX_W+2)'(nCommit);
    allocOk   = (IDX_W+2)'(alloc_cnt) <= freeSlots;
    countNext = count - (IDX_W+1)'(nCommit)
              + (allocOk ? (IDX_W+1)'(alloc_cnt) : '0);
  end

  // Retire state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= stateNext;
  end

  // Next state: a retiring halt parks the block until reset.
  always_comb begin
    stateNext = state;
    if (!flush && haltCommit) stateNext = HALTED;
  end

  // Pointers, occupancy, sticky error and the registered write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      count     <= '0;
      alloc_err <= 1'b0;
      wen0      <= 1'b0;
      wen1      <= 1'b0;
      waddr0    <= '0;
      waddr1    <= '0;
      wdata0    <= '0;
      wdata1    <= '0;
      wtag0     <= '0;
      wtag1     <= '0;
    end else if (flush) begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      head  <= flush_ptr;
      count <= '0;
      wen0  <= 1'b0;
      wen1  <= 1'b0;
    end else begin
      head      <= head + IDX_W'(nCommit);
      count     <= countNext;
      alloc_err <= alloc_err | ~allocOk;
      wen0      <= selWen0;
      wen1      <= selWen1;
      if (c0) begin
        waddr0 <= rd_entry0[DEST_MSB:DEST_LSB];
        wdata0 <= rd_entry0[VAL_MSB:VAL_LSB];
        wtag0  <= rd_addr0;
      end
      if (c1) begin
        waddr1 <= rd_entry1[DEST_MSB:DEST_LSB];
        wdata1 <= rd_entry1[VAL_MSB:VAL_LSB];
        wtag1  <= rd_addr1;
      end
    end
  end

`ifdef ROB_RETIRE_CNT_EN
  // Retired-instruction counter, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     retired <= '0;
    else if (!flush) retired <= retired + 32'(nCommit);
  end
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: a behavioural ROB model (array of entries plus
// head/count integers) predicts every cycle's outputs; directed scenarios
// cover the named corner cases, then randomized epochs stress the rest.
module tb_rob_retire;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  alloc_cnt;
  logic        flush;
  logic [5:0]  flush_ptr;
  logic [5:0]  rd_addr0, rd_addr1;
  logic [37:0] rd_entry0, rd_entry1;
  logic        wen0, wen1;
  logic [2:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic [5:0]  wtag0, wtag1, head;
  logic [6:0]  count;
  logic        stall, halted, alloc_err;
  logic [31:0] retired;

  always #5 clk = ~clk;

  // Testbench-side ROB storage, read combinationally like the real array.
  logic [37:0] mem [64];
  assign rd_entry0 = mem[rd_addr0];
  assign rd_entry1 = mem[rd_addr1];

  rob_retire dut (
    .clk(clk), .rst_n(rst_n), .alloc_cnt(alloc_cnt), .flush(flush),
    .flush_ptr(flush_ptr), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_entry0(rd_entry0), .rd_entry1(rd_entry1), .wen0(wen0), .wen1(wen1),
    .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
    .wtag0(wtag0), .wtag1(wtag1), .head(head), .count(count), .stall(stall),
    .halted(halted), .alloc_err(alloc_err), .retired(retired)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int          mHead, mCount;
  bit          mHalted, mErr;
  logic [31:0] mRetired;
  bit          eWen0, eWen1;
  logic [2:0]  eAddr0, eAddr1;
  logic [15:0] eData0, eData1;
  logic [5:0]  eTag0, eTag1;

  function automatic logic [37:0] mk(bit rdy, bit wreg, logic [2:0] dest,
                                     logic [15:0] val, bit halt, logic [15:0] pc);
    return {rdy, wreg, dest, val, halt, pc};
  endfunction

  task automatic model_reset();
    mHead = 0; mCount = 0; mHalted = 0; mErr = 0; mRetired = '0;
    eWen0 = 0; eWen1 = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wen0"}, wen0, eWen0);
    check({tag, ".wen1"}, wen1, eWen1);
    if (eWen0) begin
      check({tag, ".waddr0"}, waddr0, eAddr0);
      check({tag, ".wdata0"}, wdata0, eData0);
      check({tag, ".wtag0"},  wtag0,  eTag0);
    end
    if (eWen1) begin
      check({tag, ".waddr1"}, waddr1, eAddr1);
      check({tag, ".wdata1"}, wdata1, eData1);
      check({tag, ".wtag1"},  wtag1,  eTag1);
    end
    check({tag, ".head"},     head,     mHead);
    check({tag, ".rd_addr0"}, rd_addr0, mHead);
    check({tag, ".rd_addr1"}, rd_addr1, (mHead + 1) % 64);
    check({tag, ".count"},    count,    mCount);
    check({tag, ".stall"},    stall,    (64 - mCount) < 4);
    check({tag, ".halted"},   halted,   mHalted);
    check({tag, ".alloc_err"}, alloc_err, mErr);
`ifdef ROB_RETIRE_CNT_EN
    check({tag, ".retired"},  retired,  mRetired);
`else
    check({tag, ".retired"},  retired,  32'd0);
`endif
  endtask

  // One clock: drive inputs, predict from the model, then compare after the edge.
  task automatic cycle(input string tag, input int alloc, input bit fl, input int fp);
    int n;
    bit haltNow;
    logic [37:0] e;
    alloc_cnt = 3'(alloc);
    flush     = fl;
    flush_ptr = 6'(fp);
    n = 0; haltNow = 0; eWen0 = 0; eWen1 = 0;
    if (!fl) begin
      for (int k = 0; k < 2; k++) begin
        if (mHalted || haltNow || k >= mCount) break;
        e = mem[(mHead + k) % 64];
        if (!e[37]) break;
        n++;
        if (e[16]) haltNow = 1;
        else if (e[36]) begin
          if (k == 0) begin
            eWen0 = 1; eAddr0 = e[35:33]; eData0 = e[32:17]; eTag0 = 6'(mHead);
          end else begin
            eWen1 = 1; eAddr1 = e[35:33]; eData1 = e[32:17]; eTag1 = 6'((mHead + 1) % 64);
          end
        end
      end
      if (eWen0 && eWen1 && eAddr0 == eAddr1) eWen0 = 0;
      if (alloc > 64 - mCount + n) mErr = 1;
      else mCount += alloc;
      mCount -= n;
      mHead = (mHead + n) % 64;
      if (haltNow) mHalted = 1;
      mRetired += 32'(n);
    end else begin
      mHead = fp; mCount = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset asserted away from any edge; outputs must clear at once.
  task automatic do_reset(input string tag);
    alloc_cnt = '0; flush = 0; flush_ptr = '0;
    #2 rst_n = 0;
    #1;
    check({tag, ".rst_wen0"}, wen0, 1'b0);
    check({tag, ".rst_wen1"}, wen1, 1'b0);
    check({tag, ".rst_wdata0"}, wdata0, 16'd0);
    check({tag, ".rst_wtag1"}, wtag1, 6'd0);
    check({tag, ".rst_head"}, head, 6'd0);
    check({tag, ".rst_count"}, count, 7'd0);
    check({tag, ".rst_halted"}, halted, 1'b0);
    check({tag, ".rst_alloc_err"}, alloc_err, 1'b0);
    check({tag, ".rst_retired"}, retired, 32'd0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  // Random fill of newly allocated slots at the tail.
  task automatic fill_tail(input int alloc);
    for (int i = 0; i < alloc && i < 64 - mCount; i++)
      mem[(mHead + mCount + i) % 64] = mk($urandom_range(0, 1), $urandom_range(0, 3) != 0,
        3'($urandom), 16'($urandom), $urandom_range(0, 59) == 0, 16'($urandom));
  endtask

  initial begin
    rst_n = 0; alloc_cnt = '0; flush = 0; flush_ptr = '0;
    clear_mem();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset("init");

    // Four ready writers retire as two pairs on consecutive cycles.
    mem[0] = mk(1, 1, 3'd1, 16'd5, 0, 16'h100);
    mem[1] = mk(1, 1, 3'd2, 16'd7, 0, 16'h102);
    mem[2] = mk(1, 1, 3'd3, 16'd9, 0, 16'h104);
    mem[3] = mk(1, 1, 3'd4, 16'd0, 0, 16'h106);
    cycle("pair.alloc", 4, 0, 0);
    cycle("pair.c1", 0, 0, 0);
    check("pair.c1_wdata0", wdata0, 16'd5);
    check("pair.c1_count", count, 7'd2);
    cycle("pair.c2", 0, 0, 0);
    check("pair.c2_waddr1", waddr1, 3'd4);
    check("pair.c2_count", count, 7'd0);
    cycle("pair.idle", 0, 0, 0);

    // Head not ready blocks the ready entry behind it.
    do_reset("block");
    mem[0] = mk(0, 1, 3'd6, 16'h11, 0, 16'h0);
    mem[1] = mk(1, 1, 3'd5, 16'h22, 0, 16'h2);
    cycle("block.alloc", 2, 0, 0);
    cycle("block.wait", 0, 0, 0);
    check("block.wait_wen1", wen1, 1'b0);
    mem[0][37] = 1'b1;
    cycle("block.go", 0, 0, 0);
    check("block.go_wtag1", wtag1, 6'd1);

    // Same destination: only the younger write is issued.
    do_reset("same");
    mem[0] = mk(1, 1, 3'd2, 16'd3, 0, 16'h0);
    mem[1] = mk(1, 1, 3'd2, 16'd8, 0, 16'h2);
    cycle("same.alloc", 2, 0, 0);
    cycle("same.commit", 0, 0, 0);
    check("same.wen0", wen0, 1'b0);
    check("same.wdata1", wdata1, 16'd8);

    // Head wraps from 63 to 0.
    do_reset("wrap");
    mem[63] = mk(1, 1, 3'd1, 16'hAAAA, 0, 16'h0);
    mem[0]  = mk(1, 1, 3'd3, 16'hBBBB, 0, 16'h2);
    cycle("wrap.flush", 0, 1, 63);
    cycle("wrap.alloc", 2, 0, 0);
    cycle("wrap.commit", 0, 0, 0);
    check("wrap.wtag0", wtag0, 6'd63);
    check("wrap.head", head, 6'd1);

    // Halt at the head retires alone and parks the block.
    do_reset("halt");
    mem[0] = mk(1, 0, 3'd0, 16'd0, 1, 16'h40);
    mem[1] = mk(1, 1, 3'd7, 16'h55, 0, 16'h42);
    cycle("halt.alloc", 2, 0, 0);
    cycle("halt.commit", 0, 0, 0);
    check("halt.halted", halted, 1'b1);
    cycle("halt.after1", 1, 0, 0);
    cycle("halt.after2", 0, 0, 0);
    check("halt.count", count, 7'd2);

    // Over-allocation near full, then flush.
    do_reset("full");
    clear_mem();
    for (int i = 0; i < 15; i++) cycle("full.fill", 4, 0, 0);
    cycle("full.fill61", 1, 0, 0);
    check("full.stall", stall, 1'b1);
    cycle("full.over", 4, 0, 0);
    check("full.alloc_err", alloc_err, 1'b1);
    check("full.count", count, 7'd61);
    cycle("full.flush", 0, 1, 20);
    check("full.flush_head", head, 6'd20);

    // Randomized epochs.
    for (int ep = 0; ep < 5; ep++) begin
      do_reset("rand");
      for (int c = 0; c < 400; c++) begin
        int alloc, freeS;
        bit fl;
        for (int k = 0; k < mCount; k++)
          if ($urandom_range(0, 2) == 0) mem[(mHead + k) % 64][37] = 1'b1;
        freeS = 64 - mCount;
        alloc = $urandom_range(0, (freeS < 4) ? freeS : 4);
        if ($urandom_range(0, 19) == 0) alloc = 4;
        fl = ($urandom_range(0, 49) == 0);
        fill_tail(alloc);
        cycle("rand", alloc, fl, $urandom_range(0, 63));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
